// File: rtl/mem_access.sv
// Memory stage of the multi-cycle RV32 core: turns the execute result into a
// data-bus transaction, aligns store data to byte lanes, extends load data,
// and hands a registered result to writeback with a one-cycle valid pulse.
//
// Handshakes: upstream accepts when valid_i && ready_o (ready_o only in IDLE);
// the data bus holds dmem_req_o with stable address/we/be/wdata until
// dmem_gnt_i, then read data arrives with dmem_rvalid_i.

package mem_access_pkg;
    typedef enum logic [3:0] {
        MI_ADDI = 4'd0,
        MI_ADD  = 4'd1,
        MI_LB   = 4'd2,
        MI_LH   = 4'd3,
        MI_LW   = 4'd4,
        MI_LBU  = 4'd5,
        MI_LHU  = 4'd6,
        MI_SB   = 4'd7,
        MI_SH   = 4'd8,
        MI_SW   = 4'd9
    } control_t;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  control_t    control_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] mem_data_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [4:0]  addr_rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        valid_o,
    output control_t    control_o,
    output logic [4:0]  addr_rd_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] alu_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        accept, in_mem, in_load, in_misalign;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic [31:0] shifted, extracted;

    control_t    ctrl_q;
    logic [4:0]  rd_q;
    logic [31:0] pc_q, alu_q, wdata_q, res_q;
    logic [2:0]  size_q;
    logic [3:0]  be_q;
    logic        load_q, we_q, err_q;
    logic [7:0]  cnt_q;

    assign ready_o      = (state_q == IDLE);
    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {alu_q[31:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

    // Decode the incoming instruction: op class, misalignment, lane placement.
    always_comb begin
        accept      = valid_i && ready_o;
        in_mem      = mem_rd_i || mem_wr_i;
        in_load     = mem_rd_i;
        in_misalign = in_mem &&
                      (((mem_size_i[1:0] == 2'b01) && alu_i[0]) ||
                       (mem_size_i[1] && (alu_i[1:0] != 2'b00)));
        in_be       = 4'b1111;
        in_wdata    = mem_data_i;
        case (mem_size_i[1:0])
            2'b00: begin
                in_be    = 4'b0001 << alu_i[1:0];
                in_wdata = {4{mem_data_i[7:0]}};
            end
            2'b01: begin
                in_be    = 4'b0011 << alu_i[1:0];
                in_wdata = {2{mem_data_i[15:0]}};
            end
            default: begin
                in_be    = 4'b1111;
                in_wdata = mem_data_i;
            end
        endcase
        if (in_load) begin
            in_be = 4'b1111;
        end
    end

    // Pick the addressed byte/half out of the read word and extend it.
    always_comb begin
        shifted = dmem_rdata_i >> {alu_q[1:0], 3'b000};
        case (size_q)
            3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  extracted = {24'd0, shifted[7:0]};
            3'b101:  extracted = {16'd0, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    // Next-state logic; only aligned memory ops go onto the bus.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && in_mem && !in_misalign) state_d = REQ;
            REQ:  if (dmem_gnt_i) state_d = load_q ? WAIT : DONE;
            WAIT: if (dmem_rvalid_i || (cnt_q == CNT_LAST)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Capture registers, timeout counter and writeback output registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ctrl_q      <= MI_ADDI;
            rd_q        <= '0;
            pc_q        <= '0;
            alu_q       <= '0;
            size_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            load_q      <= 1'b0;
            we_q        <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            valid_o     <= 1'b0;
            control_o   <= MI_ADDI;
            addr_rd_o   <= '0;
            pc_plus4_o  <= '0;
            alu_o       <= '0;
            load_data_o <= '0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (accept) begin
                ctrl_q  <= control_i;
                rd_q    <= addr_rd_i;
                pc_q    <= pc_plus4_i;
                alu_q   <= alu_i;
                size_q  <= mem_size_i;
                be_q    <= in_be;
                wdata_q <= in_wdata;
                load_q  <= in_load;
                we_q    <= mem_wr_i && !in_load;
                // Nothing to do on the bus: retire straight away.
                if (!in_mem || in_misalign) begin
                    valid_o     <= 1'b1;
                    control_o   <= control_i;
                    addr_rd_o   <= addr_rd_i;
                    pc_plus4_o  <= pc_plus4_i;
                    alu_o       <= alu_i;
                    load_data_o <= '0;
                    misalign_o  <= in_misalign;
                    bus_err_o   <= 1'b0;
                end
            end
            if ((state_q == REQ) && dmem_gnt_i) begin
                cnt_q <= '0;
            end
            if (state_q == WAIT) begin
                // rvalid takes priority over a timeout in the same cycle.
                if (dmem_rvalid_i) begin
                    res_q <= extracted;
                    err_q <= 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
            if (state_q == DONE) begin
                valid_o     <= 1'b1;
                control_o   <= ctrl_q;
                addr_rd_o   <= rd_q;
                pc_plus4_o  <= pc_q;
                alu_o       <= alu_q;
                load_data_o <= load_q ? res_q : 32'd0;
                misalign_o  <= 1'b0;
                bus_err_o   <= load_q && err_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: non-memory ops, stores, sign/zero-extended
// loads, misalignment, load timeout and its rvalid race, and mid-load reset.

module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    control_t    control_i = MI_ADDI;
    logic        mem_rd_i = 1'b0;
    logic        mem_wr_i = 1'b0;
    logic [2:0]  mem_size_i = 3'b000;
    logic [31:0] alu_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] pc_plus4_i = '0;
    logic [4:0]  addr_rd_i = '0;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        valid_o;
    control_t    control_o;
    logic [4:0]  addr_rd_o;
    logic [31:0] pc_plus4_o, alu_o, load_data_o;
    logic        misalign_o, bus_err_o;

    int checks = 0;
    int failures = 0;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready_o),
        .control_i(control_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
        .mem_size_i(mem_size_i), .alu_i(alu_i), .mem_data_i(mem_data_i),
        .pc_plus4_i(pc_plus4_i), .addr_rd_i(addr_rd_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o), .control_o(control_o),
        .addr_rd_o(addr_rd_o), .pc_plus4_o(pc_plus4_o), .alu_o(alu_o),
        .load_data_o(load_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input control_t c, input logic rd, input logic wr,
                         input logic [2:0] size, input logic [31:0] alu,
                         input logic [31:0] data);
        valid_i    = 1'b1;
        control_i  = c;
        mem_rd_i   = rd;
        mem_wr_i   = wr;
        mem_size_i = size;
        alu_i      = alu;
        mem_data_i = data;
        pc_plus4_i = alu + 32'd4;
        addr_rd_i  = alu[4:0] ^ 5'h1f;
        tick();
        valid_i  = 1'b0;
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
    endtask

    task automatic run_store(input string tag, input control_t c, input logic [2:0] size,
                             input logic [31:0] alu, input logic [31:0] data,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input int gnt_delay);
        issue(c, 1'b0, 1'b1, size, alu, data);
        check({tag, "_req"}, 32'(dmem_req_o), 32'd1);
        check({tag, "_ready"}, 32'(ready_o), 32'd0);
        for (int i = 0; i < gnt_delay; i++) begin
            tick();
            check({tag, "_req_hold"}, 32'(dmem_req_o), 32'd1);
            check({tag, "_wdata_hold"}, dmem_wdata_o, exp_wdata);
        end
        check({tag, "_we"}, 32'(dmem_we_o), 32'd1);
        check({tag, "_addr"}, dmem_addr_o, exp_addr);
        check({tag, "_be"}, 32'(dmem_be_o), 32'(exp_be));
        check({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        check({tag, "_done_req"}, 32'(dmem_req_o), 32'd0);
        check({tag, "_done_valid"}, 32'(valid_o), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_ctrl"}, 32'(control_o), 32'(c));
        check({tag, "_alu"}, alu_o, alu);
        check({tag, "_ldata"}, load_data_o, 32'd0);
        check({tag, "_ready_after"}, 32'(ready_o), 32'd1);
        tick();
        check({tag, "_pulse"}, 32'(valid_o), 32'd0);
    endtask

    task automatic run_load(input string tag, input control_t c, input logic [2:0] size,
                            input logic [31:0] alu, input logic wr_too,
                            input logic [31:0] rdata, input int wait_n, input bit give,
                            input logic [31:0] exp_data, input logic exp_err);
        int lat;
        lat = 0;
        issue(c, 1'b1, wr_too, size, alu, 32'h5555_5555);
        check({tag, "_req"}, 32'(dmem_req_o), 32'd1);
        check({tag, "_we"}, 32'(dmem_we_o), 32'd0);
        check({tag, "_be"}, 32'(dmem_be_o), 32'hf);
        check({tag, "_addr"}, dmem_addr_o, {alu[31:2], 2'b00});
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            dmem_rvalid_i = give && (k == wait_n);
            dmem_rdata_i  = (give && (k == wait_n)) ? rdata : 32'hdead_beef;
            tick();
            dmem_rvalid_i = 1'b0;
            lat++;
            if (valid_o) break;
        end
        check({tag, "_latency"}, 32'(lat), give ? 32'(wait_n + 2) : 32'(TO + 1));
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_ldata"}, load_data_o, exp_data);
        check({tag, "_err"}, 32'(bus_err_o), 32'(exp_err));
        check({tag, "_mis"}, 32'(misalign_o), 32'd0);
        check({tag, "_ctrl"}, 32'(control_o), 32'(c));
        check({tag, "_alu"}, alu_o, alu);
        tick();
        check({tag, "_pulse"}, 32'(valid_o), 32'd0);
    endtask

    // Directed sequence.
    initial begin
        int seen;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ctrl", 32'(control_o), 32'(MI_ADDI));
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_ldata", load_data_o, 32'd0);

        // Non-memory op retires one cycle after accept with no bus request.
        issue(MI_ADD, 1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0);
        check("nm_valid", 32'(valid_o), 32'd1);
        check("nm_alu", alu_o, 32'h1234);
        check("nm_rd", 32'(addr_rd_o), 32'(5'h14 ^ 5'h1f));
        check("nm_pc", pc_plus4_o, 32'h1238);
        check("nm_ctrl", 32'(control_o), 32'(MI_ADD));
        check("nm_req", 32'(dmem_req_o), 32'd0);
        check("nm_ready", 32'(ready_o), 32'd1);
        tick();
        check("nm_pulse", 32'(valid_o), 32'd0);
        check("nm_hold", alu_o, 32'h1234);

        run_store("sb", MI_SB, 3'b000, 32'h103, 32'hAABB_CCDD, 32'h100, 4'b1000, 32'hDDDD_DDDD, 2);
        run_store("sh", MI_SH, 3'b001, 32'h102, 32'h1122_3344, 32'h100, 4'b1100, 32'h3344_3344, 0);
        run_store("sw", MI_SW, 3'b010, 32'h108, 32'h1122_3344, 32'h108, 4'b1111, 32'h1122_3344, 1);

        run_load("lh", MI_LH, 3'b001, 32'h202, 1'b0, 32'h8001_7FFF, 2, 1'b1, 32'hFFFF_8001, 1'b0);
        run_load("lhu", MI_LHU, 3'b101, 32'h202, 1'b0, 32'h8001_7FFF, 2, 1'b1, 32'h0000_8001, 1'b0);
        run_load("lb1", MI_LB, 3'b000, 32'h201, 1'b0, 32'h8001_7FFF, 0, 1'b1, 32'h0000_007F, 1'b0);
        run_load("lb3", MI_LB, 3'b000, 32'h203, 1'b0, 32'h8001_7FFF, 1, 1'b1, 32'hFFFF_FF80, 1'b0);
        run_load("lbu3", MI_LBU, 3'b100, 32'h203, 1'b0, 32'h8001_7FFF, 1, 1'b1, 32'h0000_0080, 1'b0);
        run_load("lw_rdwr", MI_LW, 3'b010, 32'h200, 1'b1, 32'h8001_7FFF, 0, 1'b1, 32'h8001_7FFF, 1'b0);

        // Misaligned word load: immediate retire, flagged, no request.
        issue(MI_LW, 1'b1, 1'b0, 3'b010, 32'h301, 32'h0);
        check("mis_req", 32'(dmem_req_o), 32'd0);
        check("mis_valid", 32'(valid_o), 32'd1);
        check("mis_flag", 32'(misalign_o), 32'd1);
        check("mis_ldata", load_data_o, 32'd0);
        tick();
        check("mis_pulse", 32'(valid_o), 32'd0);
        issue(MI_LH, 1'b1, 1'b0, 3'b001, 32'h305, 32'h0);
        check("mis_h_flag", 32'(misalign_o), 32'd1);
        tick();

        // Timeout, then rvalid in the very cycle the limit is reached.
        run_load("tmo", MI_LW, 3'b010, 32'h400, 1'b0, 32'h0, 0, 1'b0, 32'd0, 1'b1);
        run_load("race", MI_LW, 3'b010, 32'h404, 1'b0, 32'hCAFE_F00D, TO - 1, 1'b1, 32'hCAFE_F00D, 1'b0);

        // Reset while a load waits; a late rvalid must produce nothing.
        issue(MI_LW, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mrst_ready", 32'(ready_o), 32'd1);
        check("mrst_ctrl", 32'(control_o), 32'(MI_ADDI));
        check("mrst_valid", 32'(valid_o), 32'd0);
        check("mrst_alu", alu_o, 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234_5678;
        tick();
        dmem_rvalid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid_o || dmem_req_o) seen++;
            tick();
        end
        check("mrst_late_rvalid", 32'(seen), 32'd0);
        check("mrst_ldata", load_data_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
